// File: rtl/iq_round_sat_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iq_round_sat_stream_if                                 |
// | Description : Stream bundle for the IQ round/saturate block: input   |
// |               beat handshake, output beat handshake and the          |
// |               saturation-counter side channel.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface iq_round_sat_stream_if #(
  parameter int IN_WORD_LENGTH  = 19,
  parameter int OUT_WORD_LENGTH = 12,
  parameter int CNT_WIDTH       = 16
);
  // input side
  logic                              in_valid;
  logic                              in_ready;
  logic signed [IN_WORD_LENGTH-1:0]  i_in;
  logic signed [IN_WORD_LENGTH-1:0]  q_in;
  logic        [1:0]                 mode;

  // output side
  logic                              out_valid;
  logic                              out_ready;
  logic signed [OUT_WORD_LENGTH-1:0] i_out;
  logic signed [OUT_WORD_LENGTH-1:0] q_out;
  logic                              sat_flag;

  // saturation statistics
  logic                              clr_count;
  logic        [CNT_WIDTH-1:0]       sat_count;

  // producer / consumer / controller side (drives samples, takes results)
  modport master (
    output in_valid, i_in, q_in, mode, out_ready, clr_count,
    input  in_ready, out_valid, i_out, q_out, sat_flag, sat_count
  );

  // the rounding/saturating block itself
  modport slave (
    input  in_valid, i_in, q_in, mode, out_ready, clr_count,
    output in_ready, out_valid, i_out, q_out, sat_flag, sat_count
  );
endinterface
`default_nettype wire

// File: rtl/iq_round_sat_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : iq_round_sat_stream                                    |
// | Description : Two-stage I/Q requantiser. Stage 1 rounds away the     |
// |               extra fractional bits (4 selectable modes) into an     |
// |               exact value with one guard bit; stage 2 clips to the   |
// |               output range and flags clipped beats. Valid/ready      |
// |               stream with a sticky saturation counter.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module iq_round_sat_stream #(
  parameter int IN_WORD_LENGTH   = 19,
  parameter int IN_FLOAT_LENGTH  = 15,
  parameter int OUT_WORD_LENGTH  = 12,
  parameter int OUT_FLOAT_LENGTH = 11,
  parameter int CNT_WIDTH        = 16
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  iq_round_sat_stream_if.slave  bus
);

  // number of fractional bits removed by rounding
  localparam int c_D     = IN_FLOAT_LENGTH - OUT_FLOAT_LENGTH;
  // input sign-extended by one bit so the rounding increment never overflows
  localparam int c_EXT_W = IN_WORD_LENGTH + 1;
  // exact rounded value: integer bits plus output fraction plus one guard bit
  localparam int c_S1_W  = IN_WORD_LENGTH - c_D + 1;

  localparam logic [1:0] c_MODE_FLOOR     = 2'd0;
  localparam logic [1:0] c_MODE_HALF_UP   = 2'd1;
  localparam logic [1:0] c_MODE_HALF_EVEN = 2'd2;
  localparam logic [1:0] c_MODE_TO_ZERO   = 2'd3;

  localparam logic [c_EXT_W-1:0] c_ONE     = {{(c_EXT_W-1){1'b0}}, 1'b1};
  localparam logic [c_EXT_W-1:0] c_HALF    = c_ONE << (c_D - 1);
  localparam logic [c_EXT_W-1:0] c_HALF_M1 = c_HALF - c_ONE;
  localparam logic [c_EXT_W-1:0] c_FULL_M1 = (c_ONE << c_D) - c_ONE;

  // Every mode is expressed as floor(x + inc) so one adder serves all four:
  //   floor      : inc = 0
  //   half up    : inc = 2^(D-1)
  //   half even  : inc = 2^(D-1) - 1 + lsb_of_floor  (ties go up only when
  //                the floored value is odd; non-ties behave as nearest)
  //   toward zero: inc = 2^D - 1 for negative inputs (ceil), else 0
  function automatic logic [c_S1_W-1:0] f_round(
    input logic [IN_WORD_LENGTH-1:0] x,
    input logic [1:0]                m
  );
    logic [c_EXT_W-1:0] v_ext;
    logic [c_EXT_W-1:0] v_inc;
    logic [c_EXT_W-1:0] v_sum;
    v_ext = {x[IN_WORD_LENGTH-1], x};
    case (m)
      c_MODE_FLOOR:     v_inc = '0;
      c_MODE_HALF_UP:   v_inc = c_HALF;
      c_MODE_HALF_EVEN: v_inc = c_HALF_M1 + {{(c_EXT_W-1){1'b0}}, x[c_D]};
      c_MODE_TO_ZERO:   v_inc = x[IN_WORD_LENGTH-1] ? c_FULL_M1 : '0;
      default:          v_inc = '0;
    endcase
    v_sum = v_ext + v_inc;
    return v_sum[c_EXT_W-1:c_D];
  endfunction

  // Clip an exact stage-1 value into the output word. Returns
  // {clipped, value}; the excess integer bits are only discarded after
  // the range decision has been made.
  function automatic logic [OUT_WORD_LENGTH:0] f_sat(
    input logic [c_S1_W-1:0] v
  );
    logic v_all_ones;
    logic v_all_zeros;
    v_all_ones  = &v[c_S1_W-1:OUT_WORD_LENGTH-1];
    v_all_zeros = ~|v[c_S1_W-1:OUT_WORD_LENGTH-1];
    if (v_all_ones || v_all_zeros) begin
      return {1'b0, v[OUT_WORD_LENGTH-1:0]};
    end else if (v[c_S1_W-1]) begin
      return {1'b1, 1'b1, {(OUT_WORD_LENGTH-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(OUT_WORD_LENGTH-1){1'b1}}};
    end
  endfunction

  // pipeline state
  logic                       r_s1_valid;
  logic [c_S1_W-1:0]          r_s1_i;
  logic [c_S1_W-1:0]          r_s1_q;
  logic                       r_out_valid;
  logic [OUT_WORD_LENGTH-1:0] r_i_out;
  logic [OUT_WORD_LENGTH-1:0] r_q_out;
  logic                       r_sat_flag;
  logic [CNT_WIDTH-1:0]       r_sat_count;

  // combinational datapath and control
  logic                       w_enable;
  logic                       w_out_xfer;
  logic                       w_cnt_max;
  logic [c_S1_W-1:0]          w_i_rnd;
  logic [c_S1_W-1:0]          w_q_rnd;
  logic [OUT_WORD_LENGTH:0]   w_i_sat;
  logic [OUT_WORD_LENGTH:0]   w_q_sat;

  // Both stages move together whenever the output slot is free or being
  // drained, so a stalled output freezes the whole pipe and its inputs.
  assign w_enable   = ~r_out_valid | bus.out_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;
  assign w_cnt_max  = &r_sat_count;

  assign w_i_rnd = f_round(bus.i_in, bus.mode);
  assign w_q_rnd = f_round(bus.q_in, bus.mode);
  assign w_i_sat = f_sat(r_s1_i);
  assign w_q_sat = f_sat(r_s1_q);

  assign bus.in_ready  = w_enable & ~RST;
  assign bus.out_valid = r_out_valid;
  assign bus.i_out     = r_i_out;
  assign bus.q_out     = r_q_out;
  assign bus.sat_flag  = r_sat_flag;
  assign bus.sat_count = r_sat_count;

  // Stage 1: round each accepted beat using the mode sampled with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_i     <= '0;
      r_s1_q     <= '0;
    end else if (w_enable) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_i <= w_i_rnd;
        r_s1_q <= w_q_rnd;
      end
    end
  end

  // Stage 2: clip to the output range; the flag travels with its data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_sat_flag  <= 1'b0;
    end else if (w_enable) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_i_out    <= w_i_sat[OUT_WORD_LENGTH-1:0];
        r_q_out    <= w_q_sat[OUT_WORD_LENGTH-1:0];
        r_sat_flag <= w_i_sat[OUT_WORD_LENGTH] | w_q_sat[OUT_WORD_LENGTH];
      end
    end
  end

  // Count clipped beats as they leave; sticks at all ones, clear wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sat_count <= '0;
    end else if (bus.clr_count) begin
      r_sat_count <= '0;
    end else if (w_out_xfer && r_sat_flag && !w_cnt_max) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iq_round_sat_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_iq_round_sat_stream                                 |
// | Description : Scoreboard bench for iq_round_sat_stream (default      |
// |               parameters) plus a CNT_WIDTH=2 instance for counter    |
// |               stickiness and clear priority.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_iq_round_sat_stream;
  localparam int IWL = 19;
  localparam int IFL = 15;
  localparam int OWL = 12;
  localparam int OFL = 11;
  localparam int D   = IFL - OFL;
  localparam longint HALF = longint'(1) <<< (D - 1);
  localparam longint OMAX = (longint'(1) <<< (OWL - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OWL - 1));

  typedef struct {
    logic [OWL-1:0] i;
    logic [OWL-1:0] q;
    logic           flag;
    int             acc;
  } exp_t;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   rx_count;
  bit   lat_check;
  logic [15:0] exp_cnt;
  exp_t sb[$];
  exp_t e;

  iq_round_sat_stream_if #(.IN_WORD_LENGTH(IWL), .OUT_WORD_LENGTH(OWL), .CNT_WIDTH(16)) bus1 ();
  iq_round_sat_stream_if #(.IN_WORD_LENGTH(IWL), .OUT_WORD_LENGTH(OWL), .CNT_WIDTH(2))  bus2 ();

  iq_round_sat_stream #(
    .IN_WORD_LENGTH(IWL), .IN_FLOAT_LENGTH(IFL),
    .OUT_WORD_LENGTH(OWL), .OUT_FLOAT_LENGTH(OFL), .CNT_WIDTH(16)
  ) dut (.CLK(CLK), .RST(RST), .bus(bus1));

  iq_round_sat_stream #(
    .IN_WORD_LENGTH(IWL), .IN_FLOAT_LENGTH(IFL),
    .OUT_WORD_LENGTH(OWL), .OUT_FLOAT_LENGTH(OFL), .CNT_WIDTH(2)
  ) dut_small (.CLK(CLK), .RST(RST), .bus(bus2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference quantiser: exact integer floor/fraction split, then clip.
  // Returns {clipped, value}.
  function automatic logic [OWL:0] model_ch(input logic [IWL-1:0] x, input logic [1:0] m);
    longint xv, fl, fr, r;
    logic [OWL:0] res;
    xv = longint'($signed(x));
    fl = xv >>> D;
    fr = xv - fl * (longint'(1) <<< D);
    case (m)
      2'd0:    r = fl;
      2'd1:    r = (fr >= HALF) ? fl + 1 : fl;
      2'd2:    r = (fr > HALF) ? fl + 1 : ((fr < HALF) ? fl : fl + (fl & 1));
      default: r = (xv < 0 && fr != 0) ? fl + 1 : fl;
    endcase
    if (r > OMAX)      res = {1'b1, 1'b0, {(OWL-1){1'b1}}};
    else if (r < OMIN) res = {1'b1, 1'b1, {(OWL-1){1'b0}}};
    else               res = {1'b0, r[OWL-1:0]};
    return res;
  endfunction

  // Scoreboard monitor for the default instance: pushes on input
  // transfer, pops and compares on output transfer, models sat_count.
  always @(negedge CLK) begin
    logic [OWL:0] mi, mq;
    if (RST) begin
      exp_cnt = '0;
    end else begin
      if (bus1.out_valid && bus1.out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got i=%h q=%h, required no beat", bus1.i_out, bus1.q_out);
        end else begin
          e = sb.pop_front();
          rx_count++;
          if ({bus1.i_out, bus1.q_out, bus1.sat_flag} !== {e.i, e.q, e.flag}) begin
            n_err++;
            $display("FAIL beat_data: got i=%h q=%h f=%b, required i=%h q=%h f=%b",
                     bus1.i_out, bus1.q_out, bus1.sat_flag, e.i, e.q, e.flag);
          end
          if (lat_check) begin
            n_cmp++;
            if ((cyc - e.acc) !== 2) begin
              n_err++;
              $display("FAIL latency: got %0d, required 2", cyc - e.acc);
            end
          end
          if (!bus1.clr_count && e.flag && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (bus1.clr_count) exp_cnt = '0;
      if (bus1.in_valid && bus1.in_ready) begin
        mi = model_ch(bus1.i_in, bus1.mode);
        mq = model_ch(bus1.q_in, bus1.mode);
        sb.push_back('{i: mi[OWL-1:0], q: mq[OWL-1:0], flag: mi[OWL] | mq[OWL], acc: cyc});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    n_cmp++;
    if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", bus1.out_valid); end
    n_cmp++;
    if ({bus1.i_out, bus1.q_out} !== '0) begin n_err++; $display("FAIL rst_data: got %h %h, required 0 0", bus1.i_out, bus1.q_out); end
    n_cmp++;
    if (bus1.sat_flag !== 1'b0) begin n_err++; $display("FAIL rst_sat_flag: got %b, required 0", bus1.sat_flag); end
    n_cmp++;
    if (bus1.sat_count !== 16'd0) begin n_err++; $display("FAIL rst_sat_count: got %0d, required 0", bus1.sat_count); end
    n_cmp++;
    if (bus1.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b, required 0", bus1.in_ready); end
    n_cmp++;
    if (bus2.sat_count !== 2'd0) begin n_err++; $display("FAIL rst_small_count: got %0d, required 0", bus2.sat_count); end
    tick();
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b, required 1", bus1.in_ready); end
  endtask

  task automatic test_rounding_back_to_back();
    logic [IWL-1:0] vi[7] = '{19'h00008, 19'h7FFF8, 19'h08000, 19'h07FFC, 19'h00028, 19'h3FFFF, 19'h07FF7};
    logic [IWL-1:0] vq[7] = '{19'h00018, 19'h70000, 19'h07FFC, 19'h00000, 19'h7FFE8, 19'h40000, 19'h7FFFF};
    lat_check = 1'b1;
    bus1.out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 7; k++) begin
        tick();
        bus1.in_valid = 1'b1;
        bus1.i_in     = vi[k];
        bus1.q_in     = vq[k];
        bus1.mode     = m[1:0];
      end
    end
    tick();
    bus1.in_valid = 1'b0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
    @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL rounding_drain: got %0d pending, required 0", sb.size()); end
    lat_check = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent;
    int rx0;
    logic [OWL-1:0] snap_i, snap_q;
    logic snap_f;
    sent = 0;
    rx0  = rx_count;
    snap_i = '0; snap_q = '0; snap_f = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus1.out_ready = !(c >= 3 && c <= 5);
      bus1.in_valid  = (sent < 5);
      bus1.i_in      = 19'h00123 * 19'(sent + 1);
      bus1.q_in      = 19'h7F000 + 19'h00211 * 19'(sent);
      bus1.mode      = 2'(sent);
      @(negedge CLK);
      if (bus1.in_valid && bus1.in_ready) sent++;
      if (c == 3) begin
        n_cmp++;
        if (bus1.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b, required 1", bus1.out_valid); end
        snap_i = bus1.i_out; snap_q = bus1.q_out; snap_f = bus1.sat_flag;
      end
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if (bus1.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b, required 0", c, bus1.in_ready); end
      end
      if (c == 4 || c == 5) begin
        n_cmp++;
        if ({bus1.i_out, bus1.q_out, bus1.sat_flag} !== {snap_i, snap_q, snap_f}) begin
          n_err++;
          $display("FAIL bp_hold c%0d: got %h %h %b, required %h %h %b", c,
                   bus1.i_out, bus1.q_out, bus1.sat_flag, snap_i, snap_q, snap_f);
        end
      end
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    n_cmp++;
    if ((rx_count - rx0) !== 5 || sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d beats (%0d pending), required 5 (0)", rx_count - rx0, sb.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 120; c++) begin
      tick();
      bus1.in_valid  = ($urandom_range(0, 4) != 0);
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      bus1.i_in      = 19'($urandom);
      bus1.q_in      = ($urandom_range(0, 1) != 0) ? 19'($urandom_range(0, 16'hFFFF)) : 19'($urandom);
      bus1.mode      = 2'($urandom_range(0, 3));
    end
    tick();
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
    @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL random_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_sat_count();
    repeat (2) tick();
    @(negedge CLK);
    n_cmp++;
    if (bus1.sat_count !== exp_cnt) begin n_err++; $display("FAIL cnt_accum: got %0d, required %0d", bus1.sat_count, exp_cnt); end
    tick();
    bus1.clr_count = 1'b1;
    tick();
    bus1.clr_count = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus1.sat_count !== 16'd0) begin n_err++; $display("FAIL cnt_clear: got %0d, required 0", bus1.sat_count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      bus1.in_valid = 1'b1;
      bus1.i_in     = 19'h08000;
      bus1.q_in     = 19'h00000;
      bus1.mode     = 2'd0;
    end
    tick();
    bus1.in_valid = 1'b0;
    repeat (4) tick();
    @(negedge CLK);
    n_cmp++;
    if (bus1.sat_count !== exp_cnt || exp_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL cnt_three: got %0d, required 3", bus1.sat_count);
    end
  endtask

  task automatic test_small_counter();
    bus2.out_ready = 1'b1;
    bus2.i_in      = 19'h08000;
    bus2.q_in      = 19'h00000;
    bus2.mode      = 2'd1;
    tick();
    bus2.in_valid = 1'b1;
    repeat (5) tick();
    bus2.in_valid = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    n_cmp++;
    if (bus2.sat_count !== 2'd3) begin n_err++; $display("FAIL small_sticky: got %0d, required 3", bus2.sat_count); end
    repeat (3) tick();
    @(negedge CLK);
    n_cmp++;
    if (bus2.sat_count !== 2'd3) begin n_err++; $display("FAIL small_hold: got %0d, required 3", bus2.sat_count); end
    // clipped beat leaving in the same cycle as clr: once from 3, once from 0
    for (int r = 0; r < 2; r++) begin
      tick();
      bus2.in_valid = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      tick();
      n_cmp++;
      if ({bus2.out_valid, bus2.sat_flag} !== 2'b11) begin
        n_err++;
        $display("FAIL small_clr_beat r%0d: got v=%b f=%b, required 1 1", r, bus2.out_valid, bus2.sat_flag);
      end
      bus2.clr_count = 1'b1;
      tick();
      bus2.clr_count = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (bus2.sat_count !== 2'd0) begin n_err++; $display("FAIL small_clr_prio r%0d: got %0d, required 0", r, bus2.sat_count); end
    end
    tick();
    bus2.in_valid = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    n_cmp++;
    if (bus2.sat_count !== 2'd1) begin n_err++; $display("FAIL small_resume: got %0d, required 1", bus2.sat_count); end
  endtask

  task automatic test_reset_flush();
    bit stale;
    bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b1;
    bus1.i_in     = 19'h08000;
    bus1.q_in     = 19'h70000;
    bus1.mode     = 2'd2;
    tick();
    bus1.i_in     = 19'h00018;
    bus1.q_in     = 19'h00008;
    tick();
    bus1.in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (bus1.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b, required 0", bus1.in_ready); end
    tick();
    @(negedge CLK);
    n_cmp++;
    if (bus1.out_valid !== 1'b0 || bus1.sat_count !== 16'd0) begin
      n_err++;
      $display("FAIL flush_state: got v=%b cnt=%0d, required v=0 cnt=0", bus1.out_valid, bus1.sat_count);
    end
    sb.delete();
    tick();
    RST = 1'b0;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus1.out_valid !== 1'b0) stale = 1'b1;
      tick();
    end
    n_cmp++;
    if (stale) begin n_err++; $display("FAIL flush_stale: got stale beat, required none"); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; rx_count = 0; lat_check = 1'b0; exp_cnt = '0;
    RST = 1'b1;
    bus1.in_valid = 1'b0; bus1.i_in = '0; bus1.q_in = '0; bus1.mode = 2'd0;
    bus1.out_ready = 1'b1; bus1.clr_count = 1'b0;
    bus2.in_valid = 1'b0; bus2.i_in = '0; bus2.q_in = '0; bus2.mode = 2'd0;
    bus2.out_ready = 1'b1; bus2.clr_count = 1'b0;
    test_reset();
    test_rounding_back_to_back();
    test_backpressure();
    test_random();
    test_sat_count();
    test_small_counter();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
